// File: rtl/fifo_stream_reader.sv
// Drain stage for the synchronous FIFO: issues reads against empty, buffers two words
// and presents them as a framed valid/ready stream. Define FIFO_RD_STATS_EN to add word_count.
module fifo_stream_reader #(
  parameter int FIFO_WIDTH = 16,
  parameter int PKT_LEN    = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  fifo_empty,
  input  logic [FIFO_WIDTH-1:0] fifo_data_out,
  input  logic                  fifo_underflow,
  output logic                  fifo_rd_en,
  output logic                  m_valid,
  output logic [FIFO_WIDTH-1:0] m_data,
  output logic                  m_last,
  input  logic                  m_ready,
  output logic                  rdr_err
`ifdef FIFO_RD_STATS_EN
  ,
  output logic [31:0]           word_count
`endif
);

  localparam int BW = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(PKT_LEN - 1);

  logic [1:0]            occ;
  logic                  inflight;
  logic [BW-1:0]         beat;
  logic [FIFO_WIDTH-1:0] slot0;
  logic [FIFO_WIDTH-1:0] slot1;

  logic                  pop;
  logic [2:0]            fill;
  logic [2:0]            occ_next;
  logic [1:0]            occ_after_pop;

  assign m_valid       = (occ != 2'd0);
  assign pop           = m_valid && m_ready;
  assign m_data        = slot0;
  assign m_last        = m_valid && (beat == LAST_BEAT);

  assign fill          = {1'b0, occ} + {2'b00, inflight};
  assign occ_next      = fill - {2'b00, pop};
  assign occ_after_pop = occ - {1'b0, pop};

  // Words already buffered or in flight, less the one leaving now, must leave room.
  assign fifo_rd_en    = rst_n && !fifo_empty && (fill < (3'd2 + {2'b00, pop}));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      occ      <= 2'd0;
      inflight <= 1'b0;
      beat     <= '0;
      slot0    <= '0;
      slot1    <= '0;
      rdr_err  <= 1'b0;
    end else begin
      occ      <= occ_next[1:0];
      inflight <= fifo_rd_en;
      if (fifo_underflow)
        rdr_err <= 1'b1;
      if (pop) begin
        slot0 <= slot1;
        beat  <= (beat == LAST_BEAT) ? '0 : beat + BW'(1);
      end
      // Capture lands after the shift, so a same-cycle pop frees slot0 for the new word.
      if (inflight) begin
        if (occ_after_pop == 2'd0)
          slot0 <= fifo_data_out;
        else
          slot1 <= fifo_data_out;
      end
    end
  end

`ifdef FIFO_RD_STATS_EN
  always_ff @(posedge clk) begin
    if (!rst_n)
      word_count <= 32'd0;
    else if (pop)
      word_count <= word_count + 32'd1;
  end
`endif

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Scoreboard bench for fifo_stream_reader: behavioural FIFO source, expected-beat queue
// filled by the stimulus, and a negedge monitor that checks every accepted beat.
module tb_fifo_stream_reader;

  localparam int W  = 16;
  localparam int PL = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         fifo_empty = 1'b0;
  logic [W-1:0] fifo_data_out = '0;
  logic         fifo_underflow = 1'b0;
  logic         m_ready = 1'b1;
  logic         fifo_rd_en;
  logic         m_valid;
  logic [W-1:0] m_data;
  logic         m_last;
  logic         rdr_err;
`ifdef FIFO_RD_STATS_EN
  logic [31:0]  word_count;
`endif

  fifo_stream_reader #(.FIFO_WIDTH(W), .PKT_LEN(PL)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .fifo_empty(fifo_empty),
    .fifo_data_out(fifo_data_out),
    .fifo_underflow(fifo_underflow),
    .fifo_rd_en(fifo_rd_en),
    .m_valid(m_valid),
    .m_data(m_data),
    .m_last(m_last),
    .m_ready(m_ready),
    .rdr_err(rdr_err)
`ifdef FIFO_RD_STATS_EN
    ,
    .word_count(word_count)
`endif
  );

  always #5 clk = ~clk;

  logic [W-1:0] fq[$];
  logic [W:0]   exp_q[$];
  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Behavioural FIFO: data appears the cycle after the read, empty updates at the edge.
  always @(posedge clk) begin
    if (fifo_rd_en) begin
      if (fq.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL rd_on_empty: read issued, expected none at %0t", $time);
      end else begin
        fifo_data_out <= fq.pop_front();
      end
    end
    fifo_empty <= (fq.size() == 0);
  end

  int         pop_cnt = 0;
  logic       stall_prev = 1'b0;
  logic [W:0] held;
  logic [W:0] e;

  always @(negedge clk) begin
    if (!rst_n) begin
      stall_prev = 1'b0;
      pop_cnt    = 0;
    end else begin
      if (stall_prev) begin
        check("hold_valid", {31'd0, m_valid}, 32'd1);
        check("hold_word", {15'd0, m_last, m_data}, {15'd0, held});
      end
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_beat: got %0h, expected no beat at %0t", m_data, $time);
        end else begin
          e = exp_q.pop_front();
          check("beat", {15'd0, m_last, m_data}, {15'd0, e});
        end
`ifdef FIFO_RD_STATS_EN
        check("word_count", word_count, pop_cnt);
`endif
        pop_cnt++;
      end
      stall_prev = m_valid && !m_ready;
      held       = {m_last, m_data};
    end
  end

  task automatic push_word(input logic [W-1:0] d, input logic last);
    fq.push_back(d);
    exp_q.push_back({last, d});
    fifo_empty = 1'b0;
  endtask

  task automatic wait_drain(input int budget, input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(name, exp_q.size(), 0);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    exp_q.delete();
    fq.delete();
    fifo_empty = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  initial begin
    int rd_cnt;
    int n;
    push_word(16'hA5A5, 1'b0);

    // reset held two cycles with FIFO non-empty and sink ready
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("rst_rd_en", {31'd0, fifo_rd_en}, 32'd0);
      check("rst_m_valid", {31'd0, m_valid}, 32'd0);
      check("rst_m_last", {31'd0, m_last}, 32'd0);
      check("rst_rdr_err", {31'd0, rdr_err}, 32'd0);
`ifdef FIFO_RD_STATS_EN
      check("rst_word_count", word_count, 32'd0);
`endif
    end

    // single word latency: rd_en in N, valid in N+2
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("lat_rd_en_N", {31'd0, fifo_rd_en}, 32'd1);
    @(negedge clk);
    check("lat_valid_N1", {31'd0, m_valid}, 32'd0);
    check("lat_rd_en_empty", {31'd0, fifo_rd_en}, 32'd0);
    @(negedge clk);
    check("lat_valid_N2", {31'd0, m_valid}, 32'd1);
    check("lat_data_N2", {16'd0, m_data}, 32'h0000A5A5);
    @(negedge clk);
    check("idle_rd_en", {31'd0, fifo_rd_en}, 32'd0);
    wait_drain(10, "single_drain");

    // streaming 8 words from beat 0
    do_reset();
    for (int i = 1; i <= 8; i++)
      push_word(W'(i), (i % PL) == 0);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!m_valid && n < 10);
    check("stream_start", {31'd0, m_valid}, 32'd1);
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      check("stream_gap", {31'd0, m_valid}, 32'd1);
    end
    wait_drain(10, "stream_drain");

    // backpressure: 5 words, sink stalled 10 cycles
    @(posedge clk); #1;
    m_ready = 1'b0;
    for (int i = 1; i <= 5; i++)
      push_word(W'(i), i == 4);
    rd_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (fifo_rd_en) rd_cnt++;
    end
    check("bp_reads", rd_cnt, 2);
    check("bp_valid", {31'd0, m_valid}, 32'd1);
    check("bp_head", {16'd0, m_data}, 32'h00000001);
    @(posedge clk); #1;
    m_ready = 1'b1;
    wait_drain(30, "bp_drain");

    // underflow pulse: sticky error, stream unaffected
    @(posedge clk); #1;
    push_word(16'h00B1, 1'b0);
    push_word(16'h00B2, 1'b0);
    push_word(16'h00B3, 1'b1);
    fifo_underflow = 1'b1;
    @(negedge clk);
    check("err_same_cycle", {31'd0, rdr_err}, 32'd0);
    @(posedge clk); #1;
    fifo_underflow = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("err_sticky", {31'd0, rdr_err}, 32'd1);
    end
    wait_drain(20, "err_drain");
    do_reset();
    @(negedge clk);
    check("err_cleared", {31'd0, rdr_err}, 32'd0);
    check("post_rst_valid", {31'd0, m_valid}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    fails++;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "watchdog");
  end

endmodule
